ilm_mult_sched: RTL and testbench

ILM_MULT_SCHED -- requirements
Module: ilm_mult_sched

---
 rtl/ilm_pkg.sv | 25 ++
 rtl/ilm_ae.sv | 43 ++++
 rtl/ilm_rr_arb.sv | 45 ++++
 rtl/ilm_mult_sched.sv | 115 +++++++++++
 tb/tb_ilm_mult_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ilm_pkg.sv
//------------------------------------------------------------------------------
// Module : ilm_pkg
// Brief  : Shared widths and the S1 pipeline entry type for the ILM scheduler.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ilm_pkg;

    localparam int c_opw     = 16;  // operand width
    localparam int c_pw      = 32;  // product width
    localparam int c_kw      = 4;   // leading-one position width for c_opw
    localparam int c_idw_max = 3;   // widest requester index (NREQ <= 8)

    typedef struct packed {
        logic [c_opw-1:0]     x;
        logic [c_opw-1:0]     y;
        logic [c_idw_max-1:0] id;
        logic                 valid;
        logic                 zero;
    } s1_entry_t;

endpackage

`default_nettype wire

// File: rtl/ilm_ae.sv
//------------------------------------------------------------------------------
// Module : ilm_ae
// Brief  : Single-stage iterative logarithmic multiplier (approximate product).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ilm_ae
    import ilm_pkg::*;
(
    input  logic [c_opw-1:0] a,
    input  logic [c_opw-1:0] b,
    output logic [c_pw-1:0]  p
);

    function automatic logic [c_kw-1:0] lod(input logic [c_opw-1:0] v);
        lod = '0;
        for (int i = 0; i < c_opw; i++) begin
            if (v[i]) lod = c_kw'(i);
        end
    endfunction

    logic [c_kw-1:0]  w_ka;
    logic [c_kw-1:0]  w_kb;
    logic [c_opw-1:0] w_ra;
    logic [c_opw-1:0] w_rb;

    // p ~= 2^(ka+kb) + ra*2^kb + rb*2^ka, dropping the ra*rb term
    always_comb begin
        w_ka       = lod(a);
        w_kb       = lod(b);
        w_ra       = a;
        w_ra[w_ka] = 1'b0;
        w_rb       = b;
        w_rb[w_kb] = 1'b0;
        p = (c_pw'(1) << ({1'b0, w_ka} + {1'b0, w_kb}))
          + ({{(c_pw-c_opw){1'b0}}, w_ra} << w_kb)
          + ({{(c_pw-c_opw){1'b0}}, w_rb} << w_ka);
    end

endmodule

`default_nettype wire

// File: rtl/ilm_rr_arb.sv
//------------------------------------------------------------------------------
// Module : ilm_rr_arb
// Brief  : Round-robin arbiter; search starts at ptr and wraps modulo NREQ.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ilm_rr_arb
    import ilm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    int w_idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        w_idx  = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_idx = int'(ptr) + off;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (i == w_idx && req[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    winner   = IDW'(i);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ilm_mult_sched.sv
//------------------------------------------------------------------------------
// Module : ilm_mult_sched
// Brief  : Round-robin scheduler sharing one ilm_ae across NREQ requesters,
//          two-stage pipeline. Option macro: ILM_SCHED_ZERO_SKIP_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ilm_mult_sched
    import ilm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [c_opw*NREQ-1:0] req_x,
    input  logic [c_opw*NREQ-1:0] req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [c_pw-1:0]       rsp_p
);

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_winner;
    logic             w_any;
    logic             w_s2_adv;
    logic             w_s1_free;
    logic             w_xfer;
    logic             w_zero;
    logic [c_opw-1:0] w_x;
    logic [c_opw-1:0] w_y;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [c_pw-1:0]  w_prod;

    logic [IDW-1:0]   r_ptr;
    s1_entry_t        r_s1;
    logic             r_s2_valid;
    logic [IDW-1:0]   r_s2_id;
    logic [c_pw-1:0]  r_s2_p;

    ilm_rr_arb #(
        .NREQ   (NREQ),
        .IDW    (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_ptr),
        .grant  (w_grant),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_s2_adv  = !r_s2_valid || rsp_ready;
    assign w_s1_free = !r_s1.valid || w_s2_adv;
    // Gated by rst_n so nothing is offered while reset is held.
    assign req_ready = (rst_n && w_s1_free) ? w_grant : '0;
    assign w_xfer    = rst_n && w_s1_free && w_any;

    assign w_x       = req_x[int'(w_winner)*c_opw +: c_opw];
    assign w_y       = req_y[int'(w_winner)*c_opw +: c_opw];
    assign w_ptr_nxt = (int'(w_winner) == NREQ - 1) ? '0 : w_winner + 1'b1;

`ifdef ILM_SCHED_ZERO_SKIP_EN
    assign w_zero = (w_x == '0) || (w_y == '0);
`else
    assign w_zero = 1'b0;
`endif

    ilm_ae u_ilm_ae (
        .a (r_s1.x),
        .b (r_s1.y),
        .p (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_p     <= '0;
        end else begin
            if (w_xfer) r_ptr <= w_ptr_nxt;
            if (w_s1_free) begin
                r_s1.valid <= w_xfer;
                if (w_xfer) begin
                    r_s1.id   <= c_idw_max'(w_winner);
                    r_s1.zero <= w_zero;
                    // Zero-operand entries keep the multiplier inputs quiet.
                    if (!w_zero) begin
                        r_s1.x <= w_x;
                        r_s1.y <= w_y;
                    end
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1.valid;
                if (r_s1.valid) begin
                    r_s2_id <= IDW'(r_s1.id);
                    r_s2_p  <= r_s1.zero ? '0 : w_prod;
                end
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_id    = r_s2_id;
    assign rsp_p     = r_s2_p;

endmodule

`default_nettype wire

// File: tb/tb_ilm_mult_sched.sv
//------------------------------------------------------------------------------
// Module : tb_ilm_mult_sched
// Brief  : Self-checking bench for ilm_mult_sched against a behavioural model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ilm_mult_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_x;
    logic [16*NREQ-1:0]  req_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_p;

    ilm_mult_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] p;
        int          t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ptr_m  = 0;
    int   cyc    = 0;
    int   nxfer  = 0;

    // Reference product: leading-one decomposition with the residual cross term dropped.
    function automatic logic [31:0] ilm_ref(input int unsigned x, input int unsigned y);
        int unsigned kx = 0, ky = 0, rx, ry, t;
        longint unsigned r;
`ifdef ILM_SCHED_ZERO_SKIP_EN
        if (x == 0 || y == 0) return 32'd0;
`endif
        t = x; while (t > 1) begin t = t >> 1; kx++; end
        t = y; while (t > 1) begin t = t >> 1; ky++; end
        rx = (x == 0) ? 0 : x - (32'd1 << kx);
        ry = (y == 0) ? 0 : y - (32'd1 << ky);
        r  = (64'd1 << (kx + ky)) + (64'(rx) << ky) + (64'(ry) << kx);
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_x[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            req_y[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
        end
    endtask

    // One cycle: entered at a negedge with inputs already driven, left at the next negedge.
    task automatic cyc_step();
        int              w;
        bit              rv, free;
        logic [NREQ-1:0] er;
        #1;
        rv   = (q.size() > 0) && (cyc >= q[0].t + 2);
        free = (q.size() < 2) || (rv && rsp_ready);
        w    = -1;
        for (int off = 0; off < NREQ; off++) begin
            if (w < 0 && req_valid[(ptr_m + off) % NREQ]) w = (ptr_m + off) % NREQ;
        end
        er = '0;
        if (free && w >= 0) er[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_p", rsp_p, q[0].p);
        end
        if (req_ready != '0) nxfer++;
        @(posedge clk);
        if (rv && rsp_ready) void'(q.pop_front());
        if (free && w >= 0) begin
            q.push_back('{w, ilm_ref(32'(req_x[16*w +: 16]), 32'(req_y[16*w +: 16])), cyc});
            ptr_m = (w + 1) % NREQ;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        ptr_m = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_p", rsp_p, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        // Requester 2 alone, 3 x 5
        req_x[32 +: 16] = 16'd3;
        req_y[32 +: 16] = 16'd5;
        req_valid = 4'b0100;
        cyc_step();
        req_valid = '0;
        cyc_step();
        #1;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_p", rsp_p, 32'd14);
        cyc_step();

        // Fill both stages, then reset mid-flight
        rsp_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        cyc_step();
        rand_ops();
        cyc_step();
        do_reset();

        // All requesting, free-flowing: grants rotate 0,1,2,3,...
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1) << (k % NREQ));
            cyc_step();
        end
        req_valid = '0;
        cyc_step();
        cyc_step();

        // Back-pressure for 5 cycles: exactly two transfers fit
        rsp_ready = 1'b0;
        req_valid = '1;
        nxfer     = 0;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            cyc_step();
        end
        chk("stall_xfers", 32'(nxfer), 32'd2);
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 4; k++) cyc_step();

        // Zero operand
        req_x[0 +: 16] = 16'd0;
        req_y[0 +: 16] = 16'd1234;
        req_valid = 4'b0001;
        #1;
        chk("zero_grant", 32'(req_ready), 32'h1);
        cyc_step();
        req_valid = '0;
        cyc_step();
        #1;
`ifdef ILM_SCHED_ZERO_SKIP_EN
        chk("zero_p", rsp_p, 32'd0);
`else
        chk("zero_p", rsp_p, 32'd1234);
`endif
        cyc_step();

        // Requester 1 drops valid while ptr=1
        do_reset();
        req_valid = 4'b0001;
        cyc_step();
        req_valid = 4'b1100;
        #1;
        chk("drop_grant", 32'(req_ready), 32'h4);
        cyc_step();
        req_valid = '1;
        #1;
        chk("drop_ptr3", 32'(req_ready), 32'h8);
        cyc_step();
        req_valid = '0;
        for (int k = 0; k < 3; k++) cyc_step();

        // Random traffic with random back-pressure
        for (int k = 0; k < 400; k++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            cyc_step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) cyc_step();
        chk("drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
